// File: rtl/glitch_sweep_core_if.sv
// Signal bundle between the glitch-rig control core and the surrounding rig
// blocks (target pins, trigger-delay, glitch and target reset/power control).
`timescale 1ns/1ps
interface glitch_sweep_core_if;
    logic        target_ready;
    logic        target_success;
    logic        clean_target_clock;
    logic        trigger;
    logic        success;
    logic [31:0] delay;
    logic        set_delay;
    logic        trigger_arm;
    logic        success_arm;
    logic        target_soft_reset;
    logic        target_hard_reset;
    logic        done;

    // Core side: samples the target pins, drives everything else.
    modport master (
        input  target_ready,
        input  target_success,
        output clean_target_clock,
        output trigger,
        output success,
        output delay,
        output set_delay,
        output trigger_arm,
        output success_arm,
        output target_soft_reset,
        output target_hard_reset,
        output done
    );

    // Rig side: drives the target pins, consumes the core outputs.
    modport slave (
        output target_ready,
        output target_success,
        input  clean_target_clock,
        input  trigger,
        input  success,
        input  delay,
        input  set_delay,
        input  trigger_arm,
        input  success_arm,
        input  target_soft_reset,
        input  target_hard_reset,
        input  done
    );
endinterface

// File: rtl/glitch_sweep_core.sv
// Clock-glitch rig control core: clk/2 target clock, two armed edge
// detectors on the target READY/SUCCESS pins, and the delay sweep FSM.
`timescale 1ns/1ps

// Armed rising-edge detector producing one fixed-length pulse per arm interval.
module glitch_edge_detect #(
    parameter int unsigned TRIG_CYCLES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic sig,
    input  logic arm,
    output logic pulse
);
    localparam int CW = $clog2(TRIG_CYCLES + 1);

    logic          sync1;
    logic          sync2;
    logic          prev;
    logic          spent;
    logic [CW-1:0] count;
    logic          rise;

    assign rise  = sync2 & ~prev;
    assign pulse = (count != '0);

    // Synchronise the pin, find the rising edge and stretch it into a pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            prev  <= 1'b0;
            spent <= 1'b0;
            count <= '0;
        end else begin
            sync1 <= sig;
            sync2 <= sync1;
            prev  <= sync2;
            if (!arm) begin
                spent <= 1'b0;
            end else if (rise) begin
                spent <= 1'b1;
            end
            if (arm && rise && !spent) begin
                count <= CW'(TRIG_CYCLES);
            end else if (count != '0) begin
                count <= count - CW'(1);
            end
        end
    end
endmodule

module glitch_sweep_core #(
    parameter int unsigned TRIG_CYCLES    = 2,
    parameter int unsigned DELAY_START    = 0,
    parameter int unsigned DELAY_STEP     = 1,
    parameter int unsigned DELAY_MAX      = 1000,
    parameter int unsigned RESET_WAIT     = 320000,
    parameter int unsigned ARM_TIMEOUT    = 3200000,
    parameter int unsigned SUCCESS_WINDOW = 320000
) (
    input  logic                 clk,
    input  logic                 rst,
    glitch_sweep_core_if.master  bus
);
    // IDLE only exists so that the soft reset pulse lands on the first edge after rst.
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RESET,
        ST_HRESET,
        ST_WAIT_RST,
        ST_LOAD,
        ST_ARM,
        ST_WINDOW,
        ST_DONE
    } state_t;

    state_t      state;
    logic [31:0] timer;
    logic [31:0] delay_q;
    logic        divider;
    logic        trigger_arm_q;
    logic        success_arm_q;
    logic        set_delay_q;
    logic        soft_reset_q;
    logic        hard_reset_q;
    logic        done_q;
    logic        trig_pulse;
    logic        succ_pulse;
    logic [32:0] delay_sum;
    logic [31:0] delay_next;

    // The sum is one bit wider so a step past 2^32-1 wraps to DELAY_START.
    assign delay_sum  = 33'(delay_q) + 33'(DELAY_STEP);
    assign delay_next = (delay_sum > 33'(DELAY_MAX)) ? DELAY_START : delay_sum[31:0];

    glitch_edge_detect #(.TRIG_CYCLES(TRIG_CYCLES)) u_ready_det (
        .clk   (clk),
        .rst   (rst),
        .sig   (bus.target_ready),
        .arm   (trigger_arm_q),
        .pulse (trig_pulse)
    );

    glitch_edge_detect #(.TRIG_CYCLES(TRIG_CYCLES)) u_success_det (
        .clk   (clk),
        .rst   (rst),
        .sig   (bus.target_success),
        .arm   (success_arm_q),
        .pulse (succ_pulse)
    );

    // Divide clk by two for the target's clean clock.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            divider <= 1'b0;
        end else begin
            divider <= ~divider;
        end
    end

    // Sweep controller: reset target, program delay, arm, wait, step.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= ST_IDLE;
            timer         <= '0;
            delay_q       <= DELAY_START;
            trigger_arm_q <= 1'b0;
            success_arm_q <= 1'b0;
            set_delay_q   <= 1'b0;
            soft_reset_q  <= 1'b0;
            hard_reset_q  <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            set_delay_q  <= 1'b0;
            soft_reset_q <= 1'b0;
            hard_reset_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    state        <= ST_RESET;
                    soft_reset_q <= 1'b1;
                end
                ST_RESET, ST_HRESET: begin
                    timer <= RESET_WAIT;
                    state <= ST_WAIT_RST;
                end
                ST_WAIT_RST: begin
                    if (timer == '0) begin
                        state       <= ST_LOAD;
                        set_delay_q <= 1'b1;
                    end else begin
                        timer <= timer - 32'd1;
                    end
                end
                ST_LOAD: begin
                    state         <= ST_ARM;
                    timer         <= ARM_TIMEOUT;
                    trigger_arm_q <= 1'b1;
                end
                ST_ARM: begin
                    if (trig_pulse) begin
                        state         <= ST_WINDOW;
                        timer         <= SUCCESS_WINDOW;
                        trigger_arm_q <= 1'b0;
                        success_arm_q <= 1'b1;
                    end else if (timer == '0) begin
                        state         <= ST_HRESET;
                        hard_reset_q  <= 1'b1;
                        trigger_arm_q <= 1'b0;
                    end else begin
                        timer <= timer - 32'd1;
                    end
                end
                ST_WINDOW: begin
                    if (succ_pulse) begin
                        state         <= ST_DONE;
                        done_q        <= 1'b1;
                        success_arm_q <= 1'b0;
                    end else if (timer == '0) begin
                        state         <= ST_RESET;
                        soft_reset_q  <= 1'b1;
                        success_arm_q <= 1'b0;
                        delay_q       <= delay_next;
                    end else begin
                        timer <= timer - 32'd1;
                    end
                end
                ST_DONE: begin
                    state <= ST_DONE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.clean_target_clock = divider;
    assign bus.trigger            = trig_pulse;
    assign bus.success            = succ_pulse;
    assign bus.delay              = delay_q;
    assign bus.set_delay          = set_delay_q;
    assign bus.trigger_arm        = trigger_arm_q;
    assign bus.success_arm        = success_arm_q;
    assign bus.target_soft_reset  = soft_reset_q;
    assign bus.target_hard_reset  = hard_reset_q;
    assign bus.done               = done_q;
endmodule

// File: tb/tb_glitch_sweep_core.sv
// Bench for glitch_sweep_core: directed attempt sequence with randomised
// READY timing, checked against timing/delay rules computed in the bench.
`timescale 1ns/1ps
module tb_glitch_sweep_core;
    localparam int unsigned TRIG_CYCLES    = 2;
    localparam int unsigned DELAY_START    = 0;
    localparam int unsigned DELAY_STEP     = 3;
    localparam int unsigned DELAY_MAX      = 7;
    localparam int unsigned RESET_WAIT     = 4;
    localparam int unsigned ARM_TIMEOUT    = 10;
    localparam int unsigned SUCCESS_WINDOW = 8;

    logic clk = 1'b0;
    logic rst;

    glitch_sweep_core_if bus ();

    glitch_sweep_core #(
        .TRIG_CYCLES    (TRIG_CYCLES),
        .DELAY_START    (DELAY_START),
        .DELAY_STEP     (DELAY_STEP),
        .DELAY_MAX      (DELAY_MAX),
        .RESET_WAIT     (RESET_WAIT),
        .ARM_TIMEOUT    (ARM_TIMEOUT),
        .SUCCESS_WINDOW (SUCCESS_WINDOW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Edge counter: at a negedge, cyc is the number of posedges so far.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          total = 0;
    int          bad   = 0;
    int          rc;
    int          hit_cyc;
    int          base;
    logic [31:0] model_delay;
    logic        trig_during;

    // Next delay by plain arithmetic on unbounded integers.
    function automatic logic [31:0] model_next(input logic [31:0] d);
        longint unsigned s;
        s = longint'(d) + longint'(DELAY_STEP);
        if (s > longint'(DELAY_MAX)) return DELAY_START;
        return 32'(s);
    endfunction

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        if (bus.trigger === 1'b1) trig_during = 1'b1;
    endtask

    function automatic logic sig_val(input int sel);
        case (sel)
            0:       return bus.set_delay;
            1:       return bus.target_soft_reset;
            2:       return bus.target_hard_reset;
            3:       return bus.trigger;
            4:       return bus.done;
            default: return 1'b0;
        endcase
    endfunction

    task automatic wait_for(input int sel, input int budget, input string tag);
        logic found;
        found = 1'b0;
        for (int n = 0; n < budget && !found; n++) begin
            tick();
            if (sig_val(sel) === 1'b1) found = 1'b1;
        end
        check_output({tag, "_seen"}, {31'd0, found}, 32'd1);
        hit_cyc = cyc;
    endtask

    // One attempt, starting just after a reset pulse seen at cycle rc.
    // ready_r < 0: never raise READY. succ_j: -1 no success, -2 rst in window,
    // >= 2 raise SUCCESS that many cycles after the trigger was first seen.
    task automatic apply_stimulus(input int ready_r, input int succ_j);
        int arm_cyc;
        int k;
        int t;
        int s;
        int quiet;
        trig_during = 1'b0;
        bus.target_ready = 1'b1;
        tick();
        tick();
        bus.target_ready = 1'b0;
        wait_for(0, 12, "set_delay");
        check_output("set_delay_latency", 32'(hit_cyc - rc), 32'(RESET_WAIT + 2));
        check_output("delay_programmed", bus.delay, model_delay);
        check_output("ready_while_disarmed", {31'd0, trig_during}, 32'd0);
        tick();
        check_output("set_delay_width", {31'd0, bus.set_delay}, 32'd0);
        check_output("trigger_arm_on", {31'd0, bus.trigger_arm}, 32'd1);
        arm_cyc = cyc;
        if (ready_r < 0) begin
            wait_for(2, int'(ARM_TIMEOUT) + 5, "hard_reset");
            check_output("arm_timeout", 32'(hit_cyc - arm_cyc), 32'(ARM_TIMEOUT + 1));
            check_output("hard_trigger_arm_off", {31'd0, bus.trigger_arm}, 32'd0);
            rc = hit_cyc;
            tick();
            check_output("hard_reset_width", {31'd0, bus.target_hard_reset}, 32'd0);
        end else begin
            repeat (ready_r) tick();
            bus.target_ready = 1'b1;
            k = cyc + 1;
            wait_for(3, 14, "trigger");
            check_output("trigger_latency", 32'(hit_cyc - k), 32'd2);
            t = hit_cyc;
            tick();
            check_output("trigger_second_cycle", {31'd0, bus.trigger}, 32'd1);
            check_output("window_success_arm", {31'd0, bus.success_arm}, 32'd1);
            check_output("window_trigger_arm", {31'd0, bus.trigger_arm}, 32'd0);
            if (succ_j == -2) begin
                rst = 1'b1;
                #1;
                check_output("rst_cuts_trigger", {31'd0, bus.trigger}, 32'd0);
                check_output("rst_success_arm", {31'd0, bus.success_arm}, 32'd0);
                check_output("rst_delay", bus.delay, DELAY_START);
                check_output("rst_divider", {31'd0, bus.clean_target_clock}, 32'd0);
                check_output("rst_soft_reset", {31'd0, bus.target_soft_reset}, 32'd0);
                bus.target_ready = 1'b0;
                tick();
                tick();
                rst = 1'b0;
                base = cyc;
                tick();
                check_output("soft_after_rst", {31'd0, bus.target_soft_reset}, 32'd1);
                check_output("divider_after_rst", {31'd0, bus.clean_target_clock}, 32'd1);
                rc = cyc;
                model_delay = DELAY_START;
            end else begin
                tick();
                check_output("trigger_width", {31'd0, bus.trigger}, 32'd0);
                trig_during = 1'b0;
                if (succ_j < 0) begin
                    bus.target_ready = 1'b0;
                    tick();
                    tick();
                    bus.target_ready = 1'b1;
                    tick();
                    tick();
                    bus.target_ready = 1'b0;
                    wait_for(1, int'(SUCCESS_WINDOW) + 6, "window_expiry");
                    check_output("window_length", 32'(hit_cyc - t), 32'(SUCCESS_WINDOW + 2));
                    check_output("no_retrigger", {31'd0, trig_during}, 32'd0);
                    model_delay = model_next(model_delay);
                    check_output("delay_stepped", bus.delay, model_delay);
                    rc = hit_cyc;
                end else begin
                    repeat (succ_j - 2) tick();
                    bus.target_success = 1'b1;
                    s = cyc + 1;
                    wait_for(4, 12, "done");
                    check_output("done_latency", 32'(hit_cyc - s), 32'd3);
                    check_output("success_pulse", {31'd0, bus.success}, 32'd1);
                    check_output("done_delay", bus.delay, model_delay);
                    check_output("done_trigger_arm", {31'd0, bus.trigger_arm}, 32'd0);
                    check_output("done_success_arm", {31'd0, bus.success_arm}, 32'd0);
                    bus.target_success = 1'b0;
                    bus.target_ready   = 1'b0;
                    quiet = 0;
                    for (int i = 0; i < 30; i++) begin
                        tick();
                        if (bus.target_soft_reset === 1'b1 || bus.target_hard_reset === 1'b1 ||
                            bus.set_delay === 1'b1) quiet++;
                        if (i < 6) check_output("divider_toggle", {31'd0, bus.clean_target_clock},
                                                32'((cyc - base) % 2));
                    end
                    check_output("no_reset_after_done", 32'(quiet), 32'd0);
                    check_output("done_sticky", {31'd0, bus.done}, 32'd1);
                    check_output("delay_frozen", bus.delay, model_delay);
                end
            end
        end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: run exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b1;
        bus.target_ready   = 1'b0;
        bus.target_success = 1'b0;
        trig_during = 1'b0;
        model_delay = DELAY_START;
        repeat (3) @(negedge clk);
        check_output("reset_divider", {31'd0, bus.clean_target_clock}, 32'd0);
        check_output("reset_trigger", {31'd0, bus.trigger}, 32'd0);
        check_output("reset_success", {31'd0, bus.success}, 32'd0);
        check_output("reset_delay", bus.delay, DELAY_START);
        check_output("reset_set_delay", {31'd0, bus.set_delay}, 32'd0);
        check_output("reset_trigger_arm", {31'd0, bus.trigger_arm}, 32'd0);
        check_output("reset_success_arm", {31'd0, bus.success_arm}, 32'd0);
        check_output("reset_soft_reset", {31'd0, bus.target_soft_reset}, 32'd0);
        check_output("reset_hard_reset", {31'd0, bus.target_hard_reset}, 32'd0);
        check_output("reset_done", {31'd0, bus.done}, 32'd0);

        rst = 1'b0;
        base = cyc;
        tick();
        check_output("soft_first_edge", {31'd0, bus.target_soft_reset}, 32'd1);
        check_output("divider_first_edge", {31'd0, bus.clean_target_clock}, 32'd1);
        rc = cyc;
        tick();
        check_output("soft_reset_width", {31'd0, bus.target_soft_reset}, 32'd0);
        check_output("divider_second_edge", {31'd0, bus.clean_target_clock}, 32'd0);

        apply_stimulus(-1, -1);
        apply_stimulus(7, -1);
        for (int i = 0; i < 3; i++) apply_stimulus(int'($urandom_range(7, 0)), -1);
        apply_stimulus(int'($urandom_range(7, 0)), -2);
        apply_stimulus(int'($urandom_range(7, 0)), -1);
        apply_stimulus(int'($urandom_range(7, 0)), 2);

        rst = 1'b1;
        #1;
        check_output("done_cleared_by_rst", {31'd0, bus.done}, 32'd0);
        tick();
        rst = 1'b0;
        base = cyc;
        tick();
        check_output("soft_after_done_rst", {31'd0, bus.target_soft_reset}, 32'd1);
        rc = cyc;
        model_delay = DELAY_START;
        apply_stimulus(int'($urandom_range(7, 0)), 6);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
